// File: rtl/cache_set_ctrl.sv
// Single-set, WAYS-way associative cache controller with true-LRU replacement.
// Serves one lookup at a time; misses fetch a line from memory and fill a victim way.
module cache_set_ctrl #(
  parameter int WAYS   = 8,
  parameter int TAG_W  = 20,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              req_we,
  input  logic [LINE_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [LINE_W-1:0] rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [TAG_W-1:0]  mem_req_tag,
  input  logic              mem_fill_valid,
  input  logic [LINE_W-1:0] mem_fill_data
);

  localparam int AW = $clog2(WAYS);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [TAG_W-1:0]  tag_q;
  logic              we_q;
  logic [LINE_W-1:0] wdata_q;

  logic [WAYS-1:0]   way_valid;
  logic [TAG_W-1:0]  way_tag  [WAYS];
  logic [LINE_W-1:0] way_line [WAYS];
  logic [AW-1:0]     way_age  [WAYS];

  logic [AW-1:0]     victim_q, victim_d, hit_idx, acc_way;
  logic              hit, accept, lookup_hit, fill_take, hit_q;
  logic [LINE_W-1:0] data_q, new_line;

  assign accept     = req_valid & req_ready;
  assign lookup_hit = (state_q == LOOKUP) && hit;
  assign fill_take  = (state_q == MISS_WAIT) && mem_fill_valid;
  assign acc_way    = (state_q == LOOKUP) ? hit_idx : victim_q;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (way_valid[i] && (way_tag[i] == tag_q)) begin
        hit     = 1'b1;
        hit_idx = AW'(i);
      end
    end
  end

  // Oldest way is the fallback; any invalid way overrides it, lowest index winning.
  always_comb begin
    victim_d = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (way_age[i] == AW'(WAYS - 1)) victim_d = AW'(i);
    end
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!way_valid[i]) victim_d = AW'(i);
    end
  end

  always_comb begin
    new_line = way_line[acc_way];
    if (we_q)                         new_line = wdata_q;
    else if (state_q == MISS_WAIT)    new_line = mem_fill_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = LOOKUP;
      LOOKUP:    state_d = hit ? RESP : MISS_REQ;
      MISS_REQ:  if (mem_req_ready) state_d = MISS_WAIT;
      MISS_WAIT: if (mem_fill_valid) state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Control state, valid bits and LRU ages; ages stay a permutation of 0..WAYS-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      way_valid <= '0;
      hit_q     <= 1'b0;
      data_q    <= '0;
      for (int i = 0; i < WAYS; i++) way_age[i] <= AW'(i);
    end else begin
      state_q <= state_d;
      if (lookup_hit || fill_take) begin
        hit_q  <= lookup_hit;
        data_q <= new_line;
        for (int i = 0; i < WAYS; i++) begin
          if (way_age[i] < way_age[acc_way]) way_age[i] <= way_age[i] + AW'(1);
        end
        way_age[acc_way] <= '0;
      end
      if (fill_take) way_valid[acc_way] <= 1'b1;
    end
  end

  // Tag/line storage and request registers are qualified by valid bits, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_q   <= req_tag;
      we_q    <= req_we;
      wdata_q <= req_wdata;
    end
    if (state_q == LOOKUP) victim_q <= victim_d;
    if ((lookup_hit && we_q) || fill_take) way_line[acc_way] <= new_line;
    if (fill_take) way_tag[acc_way] <= tag_q;
  end

  assign req_ready     = (state_q == IDLE) && !rst;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_hit       = rsp_valid & hit_q;
  assign rsp_data      = rsp_valid ? data_q : '0;
  assign mem_req_valid = (state_q == MISS_REQ);
  assign mem_req_tag   = mem_req_valid ? tag_q : '0;

endmodule

// File: tb/tb_cache_set_ctrl.sv
// Directed bench for cache_set_ctrl: expected responses are queued at request time
// and compared when the controller raises rsp_valid.
module tb_cache_set_ctrl;

  localparam int WAYS   = 8;
  localparam int TAG_W  = 20;
  localparam int LINE_W = 128;

  typedef struct packed {
    logic              hit;
    logic [LINE_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [TAG_W-1:0]  req_tag;
  logic              req_we;
  logic [LINE_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_hit;
  logic [LINE_W-1:0] rsp_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [TAG_W-1:0]  mem_req_tag;
  logic              mem_fill_valid;
  logic [LINE_W-1:0] mem_fill_data;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  cache_set_ctrl #(.WAYS(WAYS), .TAG_W(TAG_W), .LINE_W(LINE_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_tag       (req_tag),
    .req_we        (req_we),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_hit       (rsp_hit),
    .rsp_data      (rsp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_tag   (mem_req_tag),
    .mem_fill_valid(mem_fill_valid),
    .mem_fill_data (mem_fill_data)
  );

  always #5 clk = ~clk;

  function automatic logic [LINE_W-1:0] lineOf(input logic [7:0] b);
    return {(LINE_W / 8){b}};
  endfunction

  task automatic checkOutput(input string name, input logic [LINE_W-1:0] obs,
                             input logic [LINE_W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic pulseReset();
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_hit", rsp_hit, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_mem_req_valid", mem_req_valid, 0);
    checkOutput("rst_mem_req_tag", mem_req_tag, 0);
    mem_fill_valid = 1'b1;
    mem_fill_data  = lineOf(8'hDD);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    mem_fill_valid = 1'b0;
    mem_fill_data  = '0;
    checkOutput("post_rst_req_ready", req_ready, 1);
    checkOutput("post_rst_no_rsp", rsp_valid, 0);
    checkOutput("post_rst_valid_bits", dut.way_valid, 0);
    checkOutput("post_rst_age3", dut.way_age[3], 3);
  endtask

  // Drives a read up to MISS_REQ (to_wait=0) or MISS_WAIT (to_wait=1), stopping at a negedge.
  task automatic startMiss(input logic [TAG_W-1:0] tag, input logic to_wait);
    req_valid = 1'b1;
    req_tag   = tag;
    req_we    = 1'b0;
    cycle();
    req_valid = 1'b0;
    cycle();
    checkOutput("start_miss_memreq", mem_req_valid, 1);
    if (to_wait) begin
      mem_req_ready = 1'b1;
      cycle();
      mem_req_ready = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [TAG_W-1:0] tag, input logic we,
                               input logic [LINE_W-1:0] wdata, input logic exp_hit,
                               input logic [LINE_W-1:0] exp_data,
                               input logic [LINE_W-1:0] fill, input int ready_delay,
                               input int fill_delay, input logic spurious);
    int   cyc;
    exp_t e;
    exp_q.push_back('{hit: exp_hit, data: exp_data});
    @(negedge clk);
    checkOutput("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_tag   = tag;
    req_we    = we;
    req_wdata = wdata;
    cycle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_tag   = '1;
    req_wdata = '0;
    cyc = 1;
    checkOutput("req_ready_busy", req_ready, 0);
    if (!exp_hit) begin
      cycle();
      cyc++;
      checkOutput("mem_req_valid", mem_req_valid, 1);
      checkOutput("mem_req_tag", mem_req_tag, tag);
      for (int i = 0; i < ready_delay; i++) begin
        mem_fill_valid = spurious && (i == 0);
        mem_fill_data  = lineOf(8'hEE);
        cycle();
        cyc++;
        mem_fill_valid = 1'b0;
        checkOutput("mem_req_hold_valid", mem_req_valid, 1);
        checkOutput("mem_req_hold_tag", mem_req_tag, tag);
        checkOutput("req_ready_stall", req_ready, 0);
      end
      mem_req_ready = 1'b1;
      cycle();
      cyc++;
      mem_req_ready = 1'b0;
      checkOutput("mem_req_dropped", mem_req_valid, 0);
      for (int i = 0; i < fill_delay; i++) begin
        cycle();
        cyc++;
      end
      mem_fill_valid = 1'b1;
      mem_fill_data  = fill;
      cycle();
      cyc++;
      mem_fill_valid = 1'b0;
      mem_fill_data  = '0;
    end
    while (!rsp_valid && cyc < 40) begin
      cycle();
      cyc++;
    end
    e = exp_q.pop_front();
    if (!rsp_valid) begin
      checkOutput("rsp_timeout", rsp_valid, 1);
    end else begin
      checkOutput("rsp_hit", rsp_hit, e.hit);
      checkOutput("rsp_data", rsp_data, e.data);
      if (exp_hit) begin
        checkOutput("hit_latency", cyc, 2);
        checkOutput("hit_no_memreq", mem_req_valid, 0);
      end
      cycle();
      checkOutput("rsp_one_cycle", rsp_valid, 0);
    end
  endtask

  initial begin
    rst            = 1'b1;
    req_valid      = 1'b0;
    req_tag        = '0;
    req_we         = 1'b0;
    req_wdata      = '0;
    mem_req_ready  = 1'b0;
    mem_fill_valid = 1'b0;
    mem_fill_data  = '0;
    #1;
    checkOutput("init_req_ready", req_ready, 0);
    checkOutput("init_rsp_valid", rsp_valid, 0);
    checkOutput("init_mem_req_valid", mem_req_valid, 0);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    checkOutput("init_ready_after_release", req_ready, 1);
    checkOutput("init_age7", dut.way_age[7], 7);

    // Cold miss on tag 1, then a hit on the same tag.
    applyStimulus(20'h00001, 1'b0, '0, 1'b0, lineOf(8'hAA), lineOf(8'hAA), 0, 1, 1'b0);
    checkOutput("fill_way0_valid", dut.way_valid[0], 1);
    checkOutput("fill_way0_age", dut.way_age[0], 0);
    applyStimulus(20'h00001, 1'b0, '0, 1'b1, lineOf(8'hAA), '0, 0, 0, 1'b0);

    // Abandoned miss in MISS_REQ, then fill all eight ways and exercise LRU eviction.
    startMiss(20'h00050, 1'b0);
    pulseReset();
    for (int t = 0; t < WAYS; t++) begin
      applyStimulus(TAG_W'(8'h10 + t), 1'b0, '0, 1'b0, lineOf(8'(8'h10 + t)),
                    lineOf(8'(8'h10 + t)), 0, 0, 1'b0);
    end
    checkOutput("full_age_way0", dut.way_age[0], 7);
    applyStimulus(20'h00010, 1'b0, '0, 1'b1, lineOf(8'h10), '0, 0, 0, 1'b0);
    checkOutput("lru_way1_oldest", dut.way_age[1], 7);
    applyStimulus(20'h00018, 1'b0, '0, 1'b0, lineOf(8'h18), lineOf(8'h18), 0, 2, 1'b0);
    checkOutput("victim_way1", dut.victim_q, 1);
    checkOutput("victim_way1_age", dut.way_age[1], 0);
    checkOutput("way0_age_after_evict", dut.way_age[0], 1);
    applyStimulus(20'h00011, 1'b0, '0, 1'b0, lineOf(8'h11), lineOf(8'h11), 0, 0, 1'b0);

    // Write hit, then read back the written line.
    applyStimulus(20'h00010, 1'b1, lineOf(8'h55), 1'b1, lineOf(8'h55), '0, 0, 0, 1'b0);
    applyStimulus(20'h00010, 1'b0, '0, 1'b1, lineOf(8'h55), '0, 0, 0, 1'b0);

    // Memory stall with a spurious fill, and a write miss that keeps the write data.
    applyStimulus(20'h00020, 1'b0, '0, 1'b0, lineOf(8'h20), lineOf(8'h20), 5, 0, 1'b1);
    applyStimulus(20'h00030, 1'b1, lineOf(8'h77), 1'b0, lineOf(8'h77), lineOf(8'h30), 1, 3, 1'b0);
    applyStimulus(20'h00030, 1'b0, '0, 1'b1, lineOf(8'h77), '0, 0, 0, 1'b0);

    // Reset in MISS_WAIT with a late fill: the miss is dropped and the cache is empty.
    @(negedge clk);
    startMiss(20'h00040, 1'b1);
    pulseReset();
    applyStimulus(20'h00040, 1'b0, '0, 1'b0, lineOf(8'h40), lineOf(8'h40), 0, 0, 1'b0);
    applyStimulus(20'h00010, 1'b0, '0, 1'b0, lineOf(8'h99), lineOf(8'h99), 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
